// File: rtl/chan_block_sender.sv
// Per-channel block-integrity FIFO feeding the 16-way link arbiter; raises req per complete block.
// Optional CHAN_BLOCK_SENDER_OVFCNT_EN adds a saturating dropped-block counter output ovf_cnt.
module chan_block_sender #(
    parameter int unsigned AW  = 10,
    parameter int unsigned BCW = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [15:0]    din,
    input  logic           din_we,
    input  logic           din_last,
    output logic           req,
    input  logic           ack,
    output logic [15:0]    dout,
    output logic [BCW-1:0] blk_pending
`ifdef CHAN_BLOCK_SENDER_OVFCNT_EN
    ,
    output logic [15:0]    ovf_cnt
`endif
);
    localparam int unsigned    Depth  = 2 ** AW;
    localparam logic [AW-1:0]  PtrOne = 1;
    localparam logic [BCW-1:0] BlkOne = 1;
    localparam logic [BCW-1:0] BlkMax = '1;

    // Each entry is {end flag, data}
    logic [16:0]    mem [Depth];
    logic [16:0]    rd_word;

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]  blk_start_q, blk_start_d;
    logic           drop_q, drop_d;
    logic           req_q, req_d;
    logic [15:0]    dout_q, dout_d;
    logic [BCW-1:0] blk_pending_q, blk_pending_d;

    logic           full;
    logic           overflow;
    logic           pop;
    logic           pop_end;
    logic           mem_we;
    logic           commit;

    assign rd_word  = mem[rd_ptr_q];
    assign full     = (wr_ptr_q + PtrOne) == rd_ptr_q;
    assign pop      = ack && req_q;
    assign pop_end  = pop && rd_word[16];
    // A commit that would push the block count past saturation is treated like a full FIFO
    assign overflow = full || (din_last && (blk_pending_q == BlkMax) && !pop_end);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        blk_start_d = blk_start_q;
        drop_d      = drop_q;
        mem_we      = 1'b0;
        commit      = 1'b0;
        if (din_we) begin
            if (drop_q) begin
                if (din_last) begin
                    drop_d = 1'b0;
                end
            end else if (overflow) begin
                wr_ptr_d = blk_start_q;
                drop_d   = !din_last;
            end else begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PtrOne;
                if (din_last) begin
                    blk_start_d = wr_ptr_q + PtrOne;
                    commit      = 1'b1;
                end
            end
        end

        rd_ptr_d = pop ? (rd_ptr_q + PtrOne) : rd_ptr_q;
        dout_d   = pop ? rd_word[15:0] : dout_q;

        blk_pending_d = blk_pending_q;
        if (commit && !pop_end) begin
            blk_pending_d = blk_pending_q + BlkOne;
        end else if (!commit && pop_end) begin
            blk_pending_d = blk_pending_q - BlkOne;
        end

        // One-cycle gap after every block end makes the arbiter move on
        req_d = (blk_pending_d != '0) && !pop_end;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= {din_last, din};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            blk_start_q   <= '0;
            drop_q        <= 1'b0;
            req_q         <= 1'b0;
            dout_q        <= '0;
            blk_pending_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            blk_start_q   <= blk_start_d;
            drop_q        <= drop_d;
            req_q         <= req_d;
            dout_q        <= dout_d;
            blk_pending_q <= blk_pending_d;
        end
    end

    assign req         = req_q;
    assign dout        = dout_q;
    assign blk_pending = blk_pending_q;

`ifdef CHAN_BLOCK_SENDER_OVFCNT_EN
    logic        drop_set;
    logic [15:0] ovf_cnt_q, ovf_cnt_d;

    assign drop_set = din_we && !drop_q && overflow;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (drop_set && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_chan_block_sender.sv
// Scoreboard bench for chan_block_sender: queue-based block model, directed and random stimulus.
module tb_chan_block_sender;
    localparam int unsigned AW    = 3;
    localparam int unsigned BCW   = 2;
    localparam int          DEPTH = 8;
    localparam int          MAXB  = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [15:0]    din = '0;
    logic           din_we = 1'b0;
    logic           din_last = 1'b0;
    logic           ack = 1'b0;
    logic           req;
    logic [15:0]    dout;
    logic [BCW-1:0] blk_pending;
`ifdef CHAN_BLOCK_SENDER_OVFCNT_EN
    logic [15:0]    ovf_cnt;
`endif

    chan_block_sender #(
        .AW (AW),
        .BCW(BCW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_we     (din_we),
        .din_last   (din_last),
        .req        (req),
        .ack        (ack),
        .dout       (dout),
        .blk_pending(blk_pending)
`ifdef CHAN_BLOCK_SENDER_OVFCNT_EN
        ,
        .ovf_cnt    (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words in FIFO, open block, committed block lengths, expected output words
    int          m_occ = 0;
    int          m_pend = 0;
    bit          m_req = 1'b0;
    bit          m_drop = 1'b0;
    int          m_ovf = 0;
    logic [15:0] partial[$];
    int          blk_len[$];
    logic [15:0] sb_q[$];

    task automatic model_clear();
        m_occ  = 0;
        m_pend = 0;
        m_req  = 1'b0;
        m_drop = 1'b0;
        m_ovf  = 0;
        partial.delete();
        blk_len.delete();
        sb_q.delete();
    endtask

    task automatic model_step();
        bit pop;
        bit pop_end;
        bit commit;
        pop     = ack && m_req;
        pop_end = 1'b0;
        commit  = 1'b0;
        if (pop && blk_len.size() > 0) begin
            blk_len[0] = blk_len[0] - 1;
            if (blk_len[0] == 0) begin
                void'(blk_len.pop_front());
                pop_end = 1'b1;
            end
        end
        if (din_we) begin
            if (m_drop) begin
                if (din_last) m_drop = 1'b0;
            end else if (m_occ == DEPTH - 1 || (din_last && m_pend == MAXB && !pop_end)) begin
                m_occ  = m_occ - partial.size();
                partial.delete();
                m_drop = !din_last;
                if (m_ovf != 65535) m_ovf++;
            end else begin
                partial.push_back(din);
                m_occ++;
                if (din_last) begin
                    foreach (partial[i]) sb_q.push_back(partial[i]);
                    blk_len.push_back(partial.size());
                    partial.delete();
                    commit = 1'b1;
                end
            end
        end
        if (pop) m_occ--;
        m_pend = m_pend + int'(commit) - int'(pop_end);
        m_req  = (m_pend != 0) && !pop_end;
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_clear();
            else model_step();
        end
    end

    // Monitor: each handshake seen before an edge retires one scoreboard word after it
    initial begin
        bit          hs;
        logic [15:0] exp_dout;
        hs       = 1'b0;
        exp_dout = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                hs       = 1'b0;
                exp_dout = '0;
            end else if (hs) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_underflow: dout 0x%0h popped, no word expected at %0t",
                             dout, $time);
                end else begin
                    exp_dout = sb_q.pop_front();
                end
            end
            check("dout", dout, exp_dout);
            check("req", req, m_req);
            check("blk_pending", blk_pending, m_pend);
`ifdef CHAN_BLOCK_SENDER_OVFCNT_EN
            check("ovf_cnt", ovf_cnt, m_ovf);
`endif
            hs = ack && req && !reset;
        end
    end

    task automatic tick(input bit we, input bit last, input bit a, input logic [15:0] d);
        din_we   = we;
        din_last = last;
        ack      = a;
        din      = d;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n, input bit a);
        repeat (n) tick(1'b0, 1'b0, a, 16'h0000);
    endtask

    task automatic send_block(input int len, input logic [15:0] base);
        for (int i = 0; i < len; i++) begin
            tick(1'b1, i == len - 1, 1'b0, base + 16'(i));
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        idle(2, 1'b1);

        // Single 4-word block, then held ack
        tick(1'b1, 1'b0, 1'b0, 16'h1111);
        tick(1'b1, 1'b0, 1'b0, 16'h2222);
        tick(1'b1, 1'b0, 1'b0, 16'h3333);
        tick(1'b1, 1'b1, 1'b0, 16'h4444);
        check("single_req_after_last", req, 1);
        idle(6, 1'b1);
        check("single_pending_end", blk_pending, 0);

        // Two queued blocks, ack held
        send_block(3, 16'hA000);
        send_block(2, 16'hB000);
        check("two_pending", blk_pending, 2);
        idle(10, 1'b1);

        // Gapped ack
        send_block(6, 16'hC000);
        repeat (24) tick(1'b0, 1'b0, 1'($urandom_range(0, 1)), 16'h0000);
        idle(8, 1'b1);

        // Overflow: 5-word block kept, 8-word block dropped
        send_block(5, 16'hD000);
        send_block(8, 16'hE000);
        check("ovf_pending", blk_pending, 1);
`ifdef CHAN_BLOCK_SENDER_OVFCNT_EN
        check("ovf_cnt_one", ovf_cnt, 1);
`endif
        idle(8, 1'b1);

        // Commit of a new block in the same cycle as an end pop
        tick(1'b1, 1'b1, 1'b0, 16'h5A5A);
        tick(1'b1, 1'b0, 1'b0, 16'h6B00);
        tick(1'b1, 1'b1, 1'b1, 16'h6B01);
        check("simul_pending", blk_pending, 1);
        check("simul_req_gap", req, 0);
        idle(1, 1'b0);
        check("simul_req_back", req, 1);
        idle(4, 1'b1);

        // Block-count saturation at 3: fourth one-word block is dropped
        for (int k = 0; k < 4; k++) tick(1'b1, 1'b1, 1'b0, 16'h7000 + 16'(k));
        check("sat_pending", blk_pending, 3);
        idle(8, 1'b1);

        // Random traffic, including over-long blocks
        repeat (600) begin
            tick($urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) != 0, 16'($urandom));
        end
        idle(20, 1'b1);

        // Asynchronous reset in the middle of a transfer
        send_block(4, 16'h8000);
        tick(1'b0, 1'b0, 1'b1, 16'h0000);
        tick(1'b0, 1'b0, 1'b1, 16'h0000);
        #1;
        reset = 1'b1;
        #1;
        check("rst_req", req, 0);
        check("rst_dout", dout, 0);
        check("rst_pending", blk_pending, 0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        send_block(3, 16'h9000);
        idle(8, 1'b1);
        check("sb_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
